// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the simplified RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes the latched IR into ALU op and mux selects, and watchdogs imem/dmem acks.
module multicycle_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_i,
    input  logic        alu_zero_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_b_o,
    output logic [1:0]  imm_sel_o,
    output logic        wb_sel_o,
    output logic        rf_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        retire_o,
    output logic        illegal_o,
    output logic        bus_err_o
);

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluop_sel_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;

    localparam bit         WD_EN   = (ACK_TIMEOUT != 0);
    localparam logic [7:0] WD_LAST = WD_EN ? 8'(ACK_TIMEOUT - 1) : 8'd0;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_wdog;
    logic       r_illegal, r_bus_err;

    instr_t     w_ir;
    logic       w_is_op, w_is_opimm, w_is_load, w_is_store, w_is_branch;
    logic       w_illegal;
    aluop_sel_t w_alu_op;
    logic       w_src_b;
    logic [1:0] w_imm_sel;
    logic       w_taken;
    logic       w_wait, w_expire;
    logic       w_unused;

    assign w_ir        = instr_t'(ir_i);
    assign w_unused    = ^{w_ir.rs1, w_ir.rs2, w_ir.rd};
    assign w_is_op     = (w_ir.opcode == OPC_OP);
    assign w_is_opimm  = (w_ir.opcode == OPC_OP_IMM);
    assign w_is_load   = (w_ir.opcode == OPC_LOAD);
    assign w_is_store  = (w_ir.opcode == OPC_STORE);
    assign w_is_branch = (w_ir.opcode == OPC_BRANCH);

    always_comb begin
        w_illegal = 1'b0;
        case (w_ir.opcode)
            OPC_OP: begin
                if (w_ir.funct7 == 7'h20)
                    w_illegal = !((w_ir.funct3 == 3'b000) || (w_ir.funct3 == 3'b101));
                else
                    w_illegal = (w_ir.funct7 != 7'h00);
            end
            OPC_OP_IMM: begin
                if (w_ir.funct3 == 3'b001)
                    w_illegal = (w_ir.funct7 != 7'h00);
                else if (w_ir.funct3 == 3'b101)
                    w_illegal = !((w_ir.funct7 == 7'h00) || (w_ir.funct7 == 7'h20));
            end
            OPC_LOAD:   w_illegal = (w_ir.funct3 == 3'b011) || (w_ir.funct3[2:1] == 2'b11);
            OPC_STORE:  w_illegal = (w_ir.funct3 > 3'b010);
            OPC_BRANCH: w_illegal = (w_ir.funct3[2:1] == 2'b01);
            default:    w_illegal = 1'b1;
        endcase
    end

    // Datapath selects; valid for any legal instruction and held across MEM/WB.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_src_b   = 1'b0;
        w_imm_sel = IMM_I;
        w_taken   = 1'b0;
        if (w_is_op || w_is_opimm) begin
            w_src_b = w_is_opimm;
            case (w_ir.funct3)
                3'b000:  w_alu_op = (w_is_op && w_ir.funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  w_alu_op = ALU_SLL;
                3'b010:  w_alu_op = ALU_SLT;
                3'b011:  w_alu_op = ALU_SLTU;
                3'b100:  w_alu_op = ALU_XOR;
                3'b101:  w_alu_op = w_ir.funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  w_alu_op = ALU_OR;
                default: w_alu_op = ALU_AND;
            endcase
        end else if (w_is_load || w_is_store) begin
            w_src_b   = 1'b1;
            w_imm_sel = w_is_store ? IMM_S : IMM_I;
        end else if (w_is_branch) begin
            w_imm_sel = IMM_B;
            case (w_ir.funct3[2:1])
                2'b10:   w_alu_op = ALU_SLT;
                2'b11:   w_alu_op = ALU_SLTU;
                default: w_alu_op = ALU_SUB;
            endcase
            // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero
            w_taken = (w_ir.funct3[0] ^ ~w_ir.funct3[2]) ? alu_zero_i : !alu_zero_i;
        end
    end

    assign w_wait   = ((r_state == S_FETCH) && !imem_ack_i) ||
                      ((r_state == S_MEM)   && !dmem_ack_i);
    assign w_expire = WD_EN && w_wait && (r_wdog == WD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        alu_op_o    = ALU_ADD;
        alu_src_b_o = 1'b0;
        imm_sel_o   = IMM_I;
        wb_sel_o    = 1'b0;
        rf_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        retire_o    = 1'b0;
        // Outputs are forced idle during reset so a late ack cannot complete anything.
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        ir_we_o     = 1'b1;
                        w_state_nxt = S_DECODE;
                    end else if (w_expire) begin
                        w_state_nxt = S_HALT;
                    end
                end
                S_DECODE: w_state_nxt = w_illegal ? S_HALT : S_EXEC;
                S_EXEC: begin
                    alu_op_o    = w_alu_op;
                    alu_src_b_o = w_src_b;
                    imm_sel_o   = w_imm_sel;
                    if (w_is_branch) begin
                        pc_we_o     = 1'b1;
                        pc_sel_o    = w_taken;
                        retire_o    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (w_is_op || w_is_opimm) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_MEM;
                    end
                end
                S_MEM: begin
                    alu_op_o    = w_alu_op;
                    alu_src_b_o = w_src_b;
                    imm_sel_o   = w_imm_sel;
                    dmem_req_o  = 1'b1;
                    dmem_we_o   = w_is_store;
                    if (dmem_ack_i) begin
                        if (w_is_load) begin
                            w_state_nxt = S_WB;
                        end else begin
                            pc_we_o     = 1'b1;
                            retire_o    = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end else if (w_expire) begin
                        w_state_nxt = S_HALT;
                    end
                end
                S_WB: begin
                    alu_op_o    = w_alu_op;
                    alu_src_b_o = w_src_b;
                    imm_sel_o   = w_imm_sel;
                    rf_we_o     = 1'b1;
                    wb_sel_o    = w_is_load;
                    pc_we_o     = 1'b1;
                    retire_o    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
                default: w_state_nxt = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wdog    <= 8'd0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Any state change restarts the count for the next FETCH/MEM wait.
            if (w_state_nxt != r_state)
                r_wdog <= 8'd0;
            else if (w_wait)
                r_wdog <= r_wdog + 8'd1;
            if ((r_state == S_DECODE) && w_illegal)
                r_illegal <= 1'b1;
            if (w_expire)
                r_bus_err <= 1'b1;
        end
    end

    assign illegal_o = r_illegal;
    assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction vector table with a scoreboard
// queue, plus hand-written watchdog and reset-during-access sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir_i;
    logic        alu_zero_i, imem_ack_i, dmem_ack_i;
    logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o;
    logic [3:0]  alu_op_o;
    logic        alu_src_b_o;
    logic [1:0]  imm_sel_o;
    logic        wb_sel_o, rf_we_o, pc_we_o, pc_sel_o, retire_o, illegal_o, bus_err_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ir_i(ir_i), .alu_zero_i(alu_zero_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
        .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .alu_op_o(alu_op_o), .alu_src_b_o(alu_src_b_o),
        .imm_sel_o(imm_sel_o), .wb_sel_o(wb_sel_o), .rf_we_o(rf_we_o),
        .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .retire_o(retire_o),
        .illegal_o(illegal_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          dly;
        int          ill;
        int          berr;
        int          cyc;
        int          op;
        int          srcb;
        int          imm;
        int          rfwe;
        int          wbsel;
        int          pcsel;
        int          dreq;
        int          dwe;
    } vec_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic zero, input int dly,
                                input int ill, input int berr, input int cyc, input int op,
                                input int srcb, input int imm, input int rfwe, input int wbsel,
                                input int pcsel, input int dreq, input int dwe);
        vec_t v;
        v.instr = instr; v.zero = zero; v.dly = dly; v.ill = ill; v.berr = berr;
        v.cyc = cyc; v.op = op; v.srcb = srcb; v.imm = imm; v.rfwe = rfwe;
        v.wbsel = wbsel; v.pcsel = pcsel; v.dreq = dreq; v.dwe = dwe;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // Runs one instruction from reset with immediate imem acks; returns what the DUT did.
    task automatic run_vec(input vec_t v, output vec_t o);
        int  dq = 0;
        int  hc = 0;
        bit  done = 0;
        o = mk(v.instr, v.zero, v.dly, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ir_i = v.instr; alu_zero_i = v.zero;
        do_reset();
        for (int c = 1; c <= 40 && !done; c++) begin
            imem_ack_i = imem_req_o;
            dmem_ack_i = dmem_req_o && (dq >= v.dly);
            @(negedge clk);
            if (c == 3) begin
                o.op = int'(alu_op_o); o.srcb = int'(alu_src_b_o); o.imm = int'(imm_sel_o);
            end
            if (dmem_req_o) begin dq++; o.dwe = o.dwe | int'(dmem_we_o); end
            if (rf_we_o) begin o.rfwe++; o.wbsel = int'(wb_sel_o); end
            if (retire_o) begin o.cyc = c; o.pcsel = int'(pc_sel_o); done = 1; end
            if (illegal_o || bus_err_o) begin
                hc++;
                if (hc >= 3) done = 1;
            end
            @(posedge clk); #1;
        end
        o.dreq = dq; o.ill = int'(illegal_o); o.berr = int'(bus_err_o);
    endtask

    initial begin
        vec_t e, o;
        int   n;
        rst = 1'b1; ir_i = '0; alu_zero_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;

        //              instr         z  dly ill be cyc op sb im rf wb pc dr dwe
        vecs.push_back(mk(32'h002081B3, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0)); // add
        vecs.push_back(mk(32'h402081B3, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 0)); // sub
        vecs.push_back(mk(32'h402091B3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // f7=20,f3=1
        vecs.push_back(mk(32'h0000A283, 0, 3, 0, 0, 8, 0, 1, 0, 1, 1, 0, 4, 0)); // lw, ack at expiry
        vecs.push_back(mk(32'h0020A223, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 1, 1)); // sw
        vecs.push_back(mk(32'h00208463, 1, 0, 0, 0, 3, 1, 0, 2, 0, 0, 1, 0, 0)); // beq taken
        vecs.push_back(mk(32'h00208463, 0, 0, 0, 0, 3, 1, 0, 2, 0, 0, 0, 0, 0)); // beq not
        vecs.push_back(mk(32'h00209463, 1, 0, 0, 0, 3, 1, 0, 2, 0, 0, 0, 0, 0)); // bne not
        vecs.push_back(mk(32'h0020C463, 0, 0, 0, 0, 3, 3, 0, 2, 0, 0, 1, 0, 0)); // blt taken
        vecs.push_back(mk(32'h0020D463, 0, 0, 0, 0, 3, 3, 0, 2, 0, 0, 0, 0, 0)); // bge not
        vecs.push_back(mk(32'h0020F463, 1, 0, 0, 0, 3, 4, 0, 2, 0, 0, 1, 0, 0)); // bgeu taken
        vecs.push_back(mk(32'h00500093, 0, 0, 0, 0, 4, 0, 1, 0, 1, 0, 0, 0, 0)); // addi
        vecs.push_back(mk(32'h4030D093, 0, 0, 0, 0, 4, 7, 1, 0, 1, 0, 0, 0, 0)); // srai
        vecs.push_back(mk(32'h0050D093, 0, 0, 0, 0, 4, 6, 1, 0, 1, 0, 0, 0, 0)); // srli
        vecs.push_back(mk(32'h0000C093, 0, 0, 0, 0, 4, 5, 1, 0, 1, 0, 0, 0, 0)); // xori
        vecs.push_back(mk(32'h002091B3, 0, 0, 0, 0, 4, 2, 0, 0, 1, 0, 0, 0, 0)); // sll
        vecs.push_back(mk(32'h0020A1B3, 0, 0, 0, 0, 4, 3, 0, 0, 1, 0, 0, 0, 0)); // slt
        vecs.push_back(mk(32'h0020B1B3, 0, 0, 0, 0, 4, 4, 0, 0, 1, 0, 0, 0, 0)); // sltu
        vecs.push_back(mk(32'h4020D1B3, 0, 0, 0, 0, 4, 7, 0, 0, 1, 0, 0, 0, 0)); // sra
        vecs.push_back(mk(32'h0020E1B3, 0, 0, 0, 0, 4, 8, 0, 0, 1, 0, 0, 0, 0)); // or
        vecs.push_back(mk(32'h0020F1B3, 0, 0, 0, 0, 4, 9, 0, 0, 1, 0, 0, 0, 0)); // and
        vecs.push_back(mk(32'h000000B7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // lui
        vecs.push_back(mk(32'h0000B283, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // ld
        vecs.push_back(mk(32'h0020A463, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // br f3=2
        vecs.push_back(mk(32'h02009093, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // slli f7=1
        vecs.push_back(mk(32'h0020B223, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // sd
        vecs.push_back(mk(32'h0000A283, 0, 10, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4, 0)); // lw timeout

        for (int i = 0; i < vecs.size(); i++) begin
            sb.push_back(vecs[i]);
            run_vec(vecs[i], o);
            e = sb.pop_front();
            chk($sformatf("v%0d illegal", i), o.ill, e.ill);
            chk($sformatf("v%0d bus_err", i), o.berr, e.berr);
            chk($sformatf("v%0d retire_cycle", i), o.cyc, e.cyc);
            chk($sformatf("v%0d rf_we_count", i), o.rfwe, e.rfwe);
            chk($sformatf("v%0d dmem_req_cycles", i), o.dreq, e.dreq);
            if (e.ill == 0) begin
                chk($sformatf("v%0d alu_op", i), o.op, e.op);
                chk($sformatf("v%0d alu_src_b", i), o.srcb, e.srcb);
                chk($sformatf("v%0d imm_sel", i), o.imm, e.imm);
                chk($sformatf("v%0d pc_sel", i), o.pcsel, e.pcsel);
            end
            if (e.rfwe > 0) chk($sformatf("v%0d wb_sel", i), o.wbsel, e.wbsel);
            if (e.dreq > 0) chk($sformatf("v%0d dmem_we", i), o.dwe, e.dwe);
        end

        // imem never acks: request for exactly ACK_TIMEOUT cycles, then halt with bus_err
        ir_i = 32'h002081B3;
        do_reset();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            imem_ack_i = 1'b0;
            @(negedge clk);
            if (imem_req_o) n++;
            @(posedge clk); #1;
        end
        chk("imem_timeout req_cycles", n, 4);
        chk("imem_timeout bus_err", int'(bus_err_o), 1);
        chk("imem_timeout req_dropped", int'(imem_req_o), 0);

        // reset state: outputs idle during reset, sticky flags cleared after it
        rst = 1'b1;
        @(negedge clk);
        chk("reset imem_req", int'(imem_req_o), 0);
        chk("reset alu_op", int'(alu_op_o), 0);
        chk("reset pc_we", int'(pc_we_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset bus_err cleared", int'(bus_err_o), 0);
        chk("reset illegal cleared", int'(illegal_o), 0);
        chk("reset fetch req", int'(imem_req_o), 1);

        // reset in the middle of a store's MEM wait, with the ack arriving late
        ir_i = 32'h0020A223;
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            imem_ack_i = imem_req_o;
            @(posedge clk); #1;
        end
        imem_ack_i = 1'b0;
        @(negedge clk);
        chk("st_rst mem_req", int'(dmem_req_o), 1);
        @(posedge clk); #1;
        rst = 1'b1; dmem_ack_i = 1'b1;
        @(negedge clk);
        chk("st_rst pc_we_in_rst", int'(pc_we_o), 0);
        chk("st_rst retire_in_rst", int'(retire_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("st_rst dmem_req", int'(dmem_req_o), 0);
        chk("st_rst imem_req", int'(imem_req_o), 1);
        chk("st_rst pc_we", int'(pc_we_o), 0);
        chk("st_rst retire", int'(retire_o), 0);
        dmem_ack_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
